wasm_div_iter: RTL and testbench

//   Multi-cycle iterative integer divider for WebAssembly i32/i64 div_s, div_u, rem_s and rem_u.

---
 rtl/wasm_div_iter.sv | 183 ++++++++++++++++++
 tb/tb_wasm_div_iter.sv | 430 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wasm_div_iter.sv
// Iterative restoring divider for the WebAssembly i32/i64 div_s, div_u, rem_s and rem_u ops.
// Each CALC cycle retires RADIX_BITS quotient bits. Divide-by-zero, signed overflow and
// unsupported op codes finish in one cycle without iterating.

package wasm_div_pkg;
    typedef enum logic [3:0] {
        ALU_ADD, ALU_SUB, ALU_MUL, ALU_AND, ALU_OR, ALU_XOR, ALU_SHL, ALU_SHR_S, ALU_SHR_U,
        ALU_DIV_S, ALU_DIV_U, ALU_REM_S, ALU_REM_U
    } alu_op_t;

    typedef enum logic [1:0] {
        TRAP_NONE, TRAP_INT_DIV_ZERO, TRAP_INT_OVERFLOW
    } trap_t;
endpackage

module wasm_div_iter
    import wasm_div_pkg::*;
#(
    parameter int WIDTH      = 64,
    parameter int RADIX_BITS = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  alu_op_t          op,
    input  logic [WIDTH-1:0] operand_a,
    input  logic [WIDTH-1:0] operand_b,
    input  logic             abort,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output trap_t            trap
);
    localparam int N     = WIDTH / RADIX_BITS;
    localparam int CNT_W = $clog2(N);
    localparam logic [WIDTH-1:0] MIN_INT = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

    state_t           state, state_next;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] rem_q, quo_q, divisor_q;
    logic             neg_quo, neg_rem, want_rem;

    logic             is_div, is_signed, special;
    trap_t            early_trap;
    logic [WIDTH-1:0] abs_a, abs_b;
    logic             accept, start_calc, early_done, finish, flush;
    logic [WIDTH:0]   step_rem;
    logic [WIDTH-1:0] step_quo, fixed;

    // Classify the incoming request and prepare the operand magnitudes.
    always_comb begin
        is_div     = op inside {ALU_DIV_S, ALU_DIV_U, ALU_REM_S, ALU_REM_U};
        is_signed  = op inside {ALU_DIV_S, ALU_REM_S};
        special    = is_signed && (operand_a == MIN_INT) && (operand_b == '1);
        abs_a      = (is_signed && operand_a[WIDTH-1]) ? -operand_a : operand_a;
        abs_b      = (is_signed && operand_b[WIDTH-1]) ? -operand_b : operand_b;
        early_trap = TRAP_NONE;
        if (is_div && operand_b == '0) begin
            early_trap = TRAP_INT_DIV_ZERO;
        end else if (special && op == ALU_DIV_S) begin
            early_trap = TRAP_INT_OVERFLOW;
        end
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic, handshake and datapath control strobes.
    // NOTE: every output of this block gets a default first, so no path leaves one unassigned and no latch is inferred.
    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        accept     = 1'b0;
        start_calc = 1'b0;
        early_done = 1'b0;
        finish     = 1'b0;
        flush      = 1'b0;
        unique case (state)
            S_IDLE: begin
                in_ready = !abort && !rst;
                accept   = in_valid && in_ready;
                if (accept) begin
                    if (!is_div || operand_b == '0 || special) begin
                        early_done = 1'b1;
                        state_next = S_DONE;
                    end else begin
                        start_calc = 1'b1;
                        state_next = S_CALC;
                    end
                end
            end
            S_CALC: begin
                if (abort) begin
                    flush      = 1'b1;
                    state_next = S_IDLE;
                end else if (cnt == '0) begin
                    finish     = 1'b1;
                    state_next = S_DONE;
                end
            end
            S_DONE: begin
                if (abort) begin
                    flush      = 1'b1;
                    state_next = S_IDLE;
                end else if (out_ready) begin
                    state_next = S_IDLE;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    // One CALC cycle: RADIX_BITS restoring steps, then the sign fixup of the would-be final values.
    // NOTE: blocking assignments chain the steps within one cycle; only registers use non-blocking.
    always_comb begin
        step_rem = {1'b0, rem_q};
        step_quo = quo_q;
        for (int i = 0; i < RADIX_BITS; i++) begin
            step_rem = {step_rem[WIDTH-1:0], step_quo[WIDTH-1]};
            step_quo = {step_quo[WIDTH-2:0], 1'b0};
            if (step_rem >= {1'b0, divisor_q}) begin
                step_rem    = step_rem - {1'b0, divisor_q};
                step_quo[0] = 1'b1;
            end
        end
        // Negating zero yields zero, so a zero result never comes out negative.
        if (want_rem) begin
            fixed = neg_rem ? -step_rem[WIDTH-1:0] : step_rem[WIDTH-1:0];
        end else begin
            fixed = neg_quo ? -step_quo : step_quo;
        end
    end

    // Iteration datapath: load magnitudes on accept, then shift/subtract once per CALC cycle.
    // NOTE: these registers carry no reset; they are always loaded on accept before anything reads them.
    always_ff @(posedge clk) begin
        if (start_calc) begin
            rem_q     <= '0;
            quo_q     <= abs_a;
            divisor_q <= abs_b;
            neg_quo   <= is_signed && (operand_a[WIDTH-1] ^ operand_b[WIDTH-1]);
            neg_rem   <= is_signed && operand_a[WIDTH-1];
            want_rem  <= op inside {ALU_REM_S, ALU_REM_U};
            cnt       <= CNT_W'(N - 1);
        end else if (state == S_CALC) begin
            rem_q <= step_rem[WIDTH-1:0];
            quo_q <= step_quo;
            cnt   <= cnt - CNT_W'(1);
        end
    end

    // Registered outputs: set on entry to DONE, cleared on consume, abort or reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            result    <= '0;
            trap      <= TRAP_NONE;
        end else if (flush) begin
            out_valid <= 1'b0;
            result    <= '0;
            trap      <= TRAP_NONE;
        end else if (early_done) begin
            out_valid <= 1'b1;
            result    <= '0;
            trap      <= early_trap;
        end else if (finish) begin
            out_valid <= 1'b1;
            result    <= fixed;
            trap      <= TRAP_NONE;
        end else if (state == S_DONE && out_ready) begin
            out_valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_wasm_div_iter.sv
// Bench for wasm_div_iter: a 64-bit radix-2 instance for directed, backpressure, abort and reset
// scenarios, and a 32-bit radix-4 instance for corner and random traffic. Expected responses are
// queued at accept and compared by per-instance monitors when the DUT presents a result.

module tb_wasm_div_iter;
    import wasm_div_pkg::*;

    localparam logic [63:0] M1    = 64'hFFFF_FFFF_FFFF_FFFF;
    localparam logic [63:0] MIN64 = 64'h8000_0000_0000_0000;

    typedef struct {
        logic [63:0] res;
        trap_t       trap;
        int          acc;
        int          lat;
    } exp_t;

    typedef struct {
        alu_op_t     op;
        logic [63:0] a;
        logic [63:0] b;
        logic [63:0] res;
        trap_t       tr;
        int          lat;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cycle = 0;
    int   n_checks = 0;
    int   n_errors = 0;

    logic        in_valid64 = 1'b0, abort64 = 1'b0, out_ready64 = 1'b1;
    logic        in_ready64, out_valid64;
    alu_op_t     op64 = ALU_ADD;
    logic [63:0] a64 = '0, b64 = '0, result64;
    trap_t       trap64;

    logic        in_valid32 = 1'b0, abort32 = 1'b0, out_ready32 = 1'b1;
    logic        in_ready32, out_valid32;
    alu_op_t     op32 = ALU_ADD;
    logic [31:0] a32 = '0, b32 = '0, result32;
    trap_t       trap32;

    exp_t q64[$];
    exp_t q32[$];
    int   last_acc64 = 0;
    int   out_hs32 = 0;
    bit   have_prev32 = 1'b0;
    bit   rnd_ready64 = 1'b0;

    wasm_div_iter #(.WIDTH(64), .RADIX_BITS(1)) dut64 (
        .clk(clk), .rst(rst), .in_valid(in_valid64), .in_ready(in_ready64), .op(op64),
        .operand_a(a64), .operand_b(b64), .abort(abort64), .out_valid(out_valid64),
        .out_ready(out_ready64), .result(result64), .trap(trap64)
    );

    wasm_div_iter #(.WIDTH(32), .RADIX_BITS(2)) dut32 (
        .clk(clk), .rst(rst), .in_valid(in_valid32), .in_ready(in_ready32), .op(op32),
        .operand_a(a32), .operand_b(b32), .abort(abort32), .out_valid(out_valid32),
        .out_ready(out_ready32), .result(result32), .trap(trap32)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cycle <= cycle + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: actual=%h required=%h (cycle %0d)", name, act, exp, cycle);
        end
    endtask

    // Wasm semantics with plain integer arithmetic on w-bit values held in 64 bits.
    function automatic void ref_model(input alu_op_t op, input logic [63:0] a, input logic [63:0] b,
                                      input int w, output logic [63:0] res, output trap_t tr,
                                      output bit early);
        logic [63:0] mask, ua, ub;
        longint      sa, sb, smin;
        bit          sgn;
        mask  = (w == 64) ? M1 : 64'h0000_0000_FFFF_FFFF;
        ua    = a & mask;
        ub    = b & mask;
        sa    = (w == 64) ? $signed(a) : $signed({{32{a[31]}}, a[31:0]});
        sb    = (w == 64) ? $signed(b) : $signed({{32{b[31]}}, b[31:0]});
        smin  = -(longint'(1) <<< (w - 1));
        sgn   = (op == ALU_DIV_S) || (op == ALU_REM_S);
        res   = '0;
        tr    = TRAP_NONE;
        early = 1'b1;
        if (!(op inside {ALU_DIV_S, ALU_DIV_U, ALU_REM_S, ALU_REM_U})) begin
            tr = TRAP_NONE;
        end else if (ub == 0) begin
            tr = TRAP_INT_DIV_ZERO;
        end else if (sgn && sa == smin && sb == -1) begin
            if (op == ALU_DIV_S) tr = TRAP_INT_OVERFLOW;
        end else begin
            early = 1'b0;
            case (op)
                ALU_DIV_U: res = ua / ub;
                ALU_REM_U: res = ua % ub;
                ALU_DIV_S: res = sa / sb;
                default:   res = sa % sb;
            endcase
            res = res & mask;
        end
    endfunction

    function automatic logic [63:0] pick(input int w);
        logic [63:0] v;
        case ($urandom_range(0, 9))
            0:       v = '0;
            1:       v = 64'd1;
            2:       v = M1;
            3:       v = 64'(1) << (w - 1);
            4:       v = (64'(1) << (w - 1)) - 64'd1;
            5, 6:    v = 64'($urandom_range(0, 40));
            7:       v = -64'($urandom_range(1, 40));
            default: v = {$urandom, $urandom};
        endcase
        return v;
    endfunction

    function automatic alu_op_t pick_op();
        case ($urandom_range(0, 12))
            0, 1, 2:   return ALU_DIV_S;
            3, 4, 5:   return ALU_DIV_U;
            6, 7, 8:   return ALU_REM_S;
            9, 10, 11: return ALU_REM_U;
            default:   return ALU_SUB;
        endcase
    endfunction

    task automatic send64(input alu_op_t op, input logic [63:0] a, input logic [63:0] b,
                          input logic [63:0] res, input trap_t tr, input int lat);
        bit done = 1'b0;
        op64 = op; a64 = a; b64 = b; in_valid64 = 1'b1;
        for (int i = 0; i < 400 && !done; i++) begin
            @(negedge clk);
            if (in_ready64) done = 1'b1;
        end
        check("accept64", in_ready64, 1);
        if (done) begin
            last_acc64 = cycle;
            q64.push_back('{res: res, trap: tr, acc: cycle, lat: lat});
        end
        @(posedge clk); #1;
    endtask

    task automatic send32(input alu_op_t op, input logic [63:0] a, input logic [63:0] b);
        logic [63:0] r;
        trap_t       t;
        bit          early;
        bit          done = 1'b0;
        ref_model(op, a, b, 32, r, t, early);
        op32 = op; a32 = a[31:0]; b32 = b[31:0]; in_valid32 = 1'b1;
        for (int i = 0; i < 200 && !done; i++) begin
            @(negedge clk);
            if (in_ready32) done = 1'b1;
        end
        check("accept32", in_ready32, 1);
        if (done) begin
            if (have_prev32) check("back_to_back32", 64'(cycle - out_hs32), 1);
            have_prev32 = 1'b1;
            q32.push_back('{res: r, trap: t, acc: cycle, lat: early ? 1 : 17});
        end
        @(posedge clk); #1;
    endtask

    task automatic drain64();
        int i = 0;
        while ((q64.size() != 0 || out_valid64) && i < 500) begin
            @(negedge clk);
            i++;
        end
        check("drain64", 64'(q64.size()), 0);
        @(posedge clk); #1;
    endtask

    task automatic drain32();
        int i = 0;
        while ((q32.size() != 0 || out_valid32) && i < 200) begin
            @(negedge clk);
            i++;
        end
        check("drain32", 64'(q32.size()), 0);
        @(posedge clk); #1;
    endtask

    task automatic wait_valid64();
        int i = 0;
        while (!out_valid64 && i < 200) begin
            @(negedge clk);
            i++;
        end
        check("wait_valid64", out_valid64, 1);
    endtask

    // Monitor for the 64-bit instance: compare each new result against the queue head.
    initial begin : mon64
        bit   seen = 1'b0;
        exp_t e;
        forever begin
            @(negedge clk);
            if (!out_valid64) begin
                seen = 1'b0;
            end else begin
                if (!seen) begin
                    seen = 1'b1;
                    if (q64.size() == 0) begin
                        check("unexpected_out64", out_valid64, 0);
                    end else begin
                        e = q64.pop_front();
                        check("result64", result64, e.res);
                        check("trap64", trap64, e.trap);
                        check("latency64", 64'(cycle - e.acc), 64'(e.lat));
                    end
                end
                if (out_ready64) seen = 1'b0;
            end
        end
    end

    // Monitor for the 32-bit instance; also records the output handshake cycle.
    initial begin : mon32
        bit   seen = 1'b0;
        exp_t e;
        forever begin
            @(negedge clk);
            if (!out_valid32) begin
                seen = 1'b0;
            end else begin
                if (!seen) begin
                    seen = 1'b1;
                    if (q32.size() == 0) begin
                        check("unexpected_out32", out_valid32, 0);
                    end else begin
                        e = q32.pop_front();
                        check("result32", {32'b0, result32}, e.res);
                        check("trap32", trap32, e.trap);
                        check("latency32", 64'(cycle - e.acc), 64'(e.lat));
                    end
                end
                if (out_ready32) begin
                    seen     = 1'b0;
                    out_hs32 = cycle;
                end
            end
        end
    end

    // Random output backpressure for the 64-bit instance when enabled.
    initial begin : ready_gen
        forever begin
            @(posedge clk); #1;
            if (rnd_ready64) out_ready64 = 1'($urandom_range(0, 1));
        end
    end

    initial begin : watchdog
        #3000000;
        $display("FAIL watchdog: time limit reached at cycle %0d", cycle);
        $fatal(1, "watchdog");
    end

    initial begin : main
        vec_t        dir[$];
        logic [63:0] r, a, b;
        trap_t       t;
        bit          early, rose;
        alu_op_t     op;
        logic [63:0] corner[5];

        // Reset state while rst is high.
        #12;
        check("rst_in_ready64", in_ready64, 0);
        check("rst_out_valid64", out_valid64, 0);
        check("rst_result64", result64, 0);
        check("rst_trap64", trap64, TRAP_NONE);
        check("rst_in_ready32", in_ready32, 0);
        check("rst_out_valid32", out_valid32, 0);
        @(posedge clk); #3 rst = 1'b0;
        @(negedge clk);
        check("idle_in_ready64", in_ready64, 1);
        @(posedge clk); #1;

        // Directed 64-bit vectors.
        dir.push_back('{ALU_DIV_U, 64'd100, 64'd7, 64'd14, TRAP_NONE, 65});
        dir.push_back('{ALU_DIV_S, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, TRAP_NONE, 65});
        dir.push_back('{ALU_REM_S, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, M1, TRAP_NONE, 65});
        dir.push_back('{ALU_REM_S, 64'd7, 64'hFFFF_FFFF_FFFF_FFFE, 64'd1, TRAP_NONE, 65});
        dir.push_back('{ALU_REM_U, M1, 64'd10, 64'd5, TRAP_NONE, 65});
        dir.push_back('{ALU_DIV_U, 64'd55, 64'd0, 64'd0, TRAP_INT_DIV_ZERO, 1});
        dir.push_back('{ALU_REM_S, 64'hFFFF_FFFF_FFFF_FFF9, 64'd0, 64'd0, TRAP_INT_DIV_ZERO, 1});
        dir.push_back('{ALU_DIV_S, MIN64, M1, 64'd0, TRAP_INT_OVERFLOW, 1});
        dir.push_back('{ALU_REM_S, MIN64, M1, 64'd0, TRAP_NONE, 1});
        dir.push_back('{ALU_ADD, 64'd3, 64'd4, 64'd0, TRAP_NONE, 1});
        dir.push_back('{ALU_DIV_S, MIN64, 64'd1, MIN64, TRAP_NONE, 65});
        dir.push_back('{ALU_REM_S, 64'hFFFF_FFFF_FFFF_FFFA, 64'd3, 64'd0, TRAP_NONE, 65});
        dir.push_back('{ALU_DIV_S, 64'd3, 64'hFFFF_FFFF_FFFF_FFF9, 64'd0, TRAP_NONE, 65});
        dir.push_back('{ALU_DIV_U, M1, 64'd1, M1, TRAP_NONE, 65});
        dir.push_back('{ALU_DIV_S, 64'hFFFF_FFFF_FFFF_FF9C, 64'hFFFF_FFFF_FFFF_FFF9, 64'd14, TRAP_NONE, 65});
        dir.push_back('{ALU_REM_S, 64'hFFFF_FFFF_FFFF_FF9C, 64'hFFFF_FFFF_FFFF_FFF9,
                        64'hFFFF_FFFF_FFFF_FFFE, TRAP_NONE, 65});
        foreach (dir[i]) send64(dir[i].op, dir[i].a, dir[i].b, dir[i].res, dir[i].tr, dir[i].lat);
        in_valid64 = 1'b0;
        drain64();

        // Backpressure: result held stable in DONE until out_ready.
        out_ready64 = 1'b0;
        send64(ALU_DIV_U, 64'd1000, 64'd10, 64'd100, TRAP_NONE, 65);
        in_valid64 = 1'b0;
        wait_valid64();
        for (int i = 0; i < 10; i++) begin
            check("bp_result", result64, 100);
            check("bp_trap", trap64, TRAP_NONE);
            check("bp_in_ready", in_ready64, 0);
            check("bp_valid_hold", out_valid64, 1);
            @(negedge clk);
        end
        @(posedge clk); #1 out_ready64 = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("bp_release_in_ready", in_ready64, 1);
        check("bp_release_valid", out_valid64, 0);
        @(posedge clk); #1;

        // Abort on the 20th CALC cycle.
        send64(ALU_DIV_U, 64'd12345678, 64'd17, 64'd726216, TRAP_NONE, 65);
        in_valid64 = 1'b0;
        while (cycle < last_acc64 + 20) begin
            @(posedge clk); #1;
        end
        abort64 = 1'b1;
        @(negedge clk);
        check("abort_calc_in_ready", in_ready64, 0);
        @(posedge clk); #1 abort64 = 1'b0;
        void'(q64.pop_back());
        @(negedge clk);
        check("abort_next_in_ready", in_ready64, 1);
        check("abort_next_valid", out_valid64, 0);
        rose = 1'b0;
        repeat (70) begin
            @(negedge clk);
            if (out_valid64) rose = 1'b1;
        end
        check("abort_no_output", rose, 0);

        // abort in IDLE blocks acceptance.
        @(posedge clk); #1;
        op64 = ALU_DIV_U; a64 = 64'd9; b64 = 64'd3; in_valid64 = 1'b1; abort64 = 1'b1;
        @(negedge clk);
        check("abort_idle_in_ready", in_ready64, 0);
        @(posedge clk); #1 abort64 = 1'b0;
        send64(ALU_DIV_U, 64'd9, 64'd3, 64'd3, TRAP_NONE, 65);
        in_valid64 = 1'b0;
        drain64();

        // Reset pulsed mid-CALC.
        send64(ALU_DIV_U, M1, 64'd3, 64'h5555_5555_5555_5555, TRAP_NONE, 65);
        in_valid64 = 1'b0;
        repeat (10) @(posedge clk);
        #3 rst = 1'b1;
        #1;
        check("rst_calc_valid", out_valid64, 0);
        check("rst_calc_result", result64, 0);
        check("rst_calc_trap", trap64, TRAP_NONE);
        check("rst_calc_in_ready", in_ready64, 0);
        void'(q64.pop_back());
        @(negedge clk); #2 rst = 1'b0;
        @(negedge clk);
        check("rst_calc_recover", in_ready64, 1);

        // Reset pulsed mid-DONE while a trap is presented.
        @(posedge clk); #1 out_ready64 = 1'b0;
        send64(ALU_DIV_U, 64'd5, 64'd0, 64'd0, TRAP_INT_DIV_ZERO, 1);
        in_valid64 = 1'b0;
        @(negedge clk);
        check("rst_done_valid_before", out_valid64, 1);
        #2 rst = 1'b1;
        #1;
        check("rst_done_valid", out_valid64, 0);
        check("rst_done_trap", trap64, TRAP_NONE);
        check("rst_done_result", result64, 0);
        @(posedge clk); #2 rst = 1'b0; out_ready64 = 1'b1;
        @(negedge clk);
        check("rst_done_recover", in_ready64, 1);
        @(posedge clk); #1;

        // Random 64-bit traffic with random backpressure.
        rnd_ready64 = 1'b1;
        for (int i = 0; i < 120; i++) begin
            op = pick_op();
            a  = pick(64);
            b  = pick(64);
            ref_model(op, a, b, 64, r, t, early);
            send64(op, a, b, r, t, early ? 1 : 65);
        end
        in_valid64  = 1'b0;
        rnd_ready64 = 1'b0;
        @(posedge clk); #2 out_ready64 = 1'b1;
        drain64();

        // 32-bit radix-4 instance: corner grid, then random back-to-back traffic.
        corner[0] = 64'd0;
        corner[1] = 64'd1;
        corner[2] = 64'hFFFF_FFFF;
        corner[3] = 64'h8000_0000;
        corner[4] = 64'h7FFF_FFFF;
        for (int k = 0; k < 4; k++) begin
            case (k)
                0:       op = ALU_DIV_S;
                1:       op = ALU_DIV_U;
                2:       op = ALU_REM_S;
                default: op = ALU_REM_U;
            endcase
            for (int i = 0; i < 5; i++) begin
                for (int j = 0; j < 5; j++) send32(op, corner[i], corner[j]);
            end
        end
        for (int i = 0; i < 2000; i++) send32(pick_op(), pick(32), pick(32));
        in_valid32 = 1'b0;
        drain32();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
